// File: rtl/i2s_writer_defines.sv
// Shared constants and state encoding for the I2S writer PHY.
package i2s_writer_defines;

   localparam int SLOT_BITS   = 32;
   localparam int SAMPLE_BITS = 24;
   localparam int CHAN_BIT    = 31;
   localparam int COUNT_BITS  = $clog2(SLOT_BITS);
   localparam logic [COUNT_BITS-1:0] LAST_BIT = COUNT_BITS'(SLOT_BITS - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // One-bit I2S delay in front of the sample, zero padding behind it.
   function automatic logic [SLOT_BITS-1:0] slot_word(input logic [SAMPLE_BITS-1:0] sample);
      return {1'b0, sample, {(SLOT_BITS - SAMPLE_BITS - 1){1'b0}}};
   endfunction

endpackage

// File: rtl/i2s_writer_phy.sv
// I2S transmitter: fetches words from a ping-pong read FIFO into a one-word
// buffer and serializes them MSB first into 32-bit left/right slots.
module i2s_writer_phy
   import i2s_writer_defines::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_enable,
   input  logic        i_rfifo_ready,
   input  logic [23:0] i_rfifo_size,
   output logic        o_rfifo_activate,
   output logic        o_rfifo_strobe,
   input  logic [31:0] i_rfifo_data,
   output logic        o_i2s_lr,
   output logic        o_i2s_data,
   output logic        o_underflow,
   output logic        o_sync_error,
   output logic [31:0] debug
);

   state_e                  state_q, state_d;
   logic [COUNT_BITS-1:0]   bit_count_q, bit_count_d;
   logic                    lr_q, lr_d;
   logic [SLOT_BITS-1:0]    shift_q, shift_d;
   logic                    underflow_q, underflow_d;
   logic                    sync_error_q, sync_error_d;
   logic                    act_q, act_d;
   logic                    act_first_q, act_first_d;
   logic [23:0]             r_count_q, r_count_d;
   logic                    buf_valid_q, buf_valid_d;
   logic [SAMPLE_BITS:0]    buf_q, buf_d;

   logic running;
   logic strobe;
   logic take;
   logic unused_bits;

   assign unused_bits = ^i_rfifo_data[CHAN_BIT-1:SAMPLE_BITS];

   // A clock with enable low already counts as leaving RUN.
   assign running = (state_q == ST_RUN) && i_enable;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path infers a latch.
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (i_enable)  state_d = ST_RUN;
         ST_RUN:  if (!i_enable) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // FIFO fetch: owns the block handshake and refills the one-word buffer.
   always_comb begin
      act_d       = 1'b0;
      act_first_d = 1'b0;
      r_count_d   = '0;
      strobe      = 1'b0;
      buf_valid_d = 1'b0;
      buf_d       = buf_q;
      if (running) begin
         act_d       = act_q;
         r_count_d   = r_count_q;
         buf_valid_d = buf_valid_q;
         if (!act_q) begin
            if (i_rfifo_ready) begin
               act_d       = 1'b1;
               act_first_d = 1'b1;
               r_count_d   = '0;
            end
         end else if (r_count_q == i_rfifo_size) begin
            act_d = 1'b0;
         end else if (!buf_valid_q && !act_first_q) begin
            strobe    = 1'b1;
            r_count_d = r_count_q + 24'd1;
         end
         if (strobe) begin
            buf_valid_d = 1'b1;
            buf_d       = {i_rfifo_data[CHAN_BIT], i_rfifo_data[SAMPLE_BITS-1:0]};
         end else if (take) begin
            buf_valid_d = 1'b0;
         end
      end
   end

   // Serializer: slot timing, word select and the shift register load.
   always_comb begin
      bit_count_d  = '0;
      lr_d         = 1'b0;
      shift_d      = '0;
      underflow_d  = 1'b0;
      sync_error_d = 1'b0;
      take         = 1'b0;
      if (running) begin
         bit_count_d = bit_count_q + 1'b1;
         lr_d        = lr_q;
         shift_d     = {shift_q[SLOT_BITS-2:0], 1'b0};
         if (bit_count_q == LAST_BIT) begin
            lr_d = ~lr_q;
            if (!buf_valid_q) begin
               shift_d     = '0;
               underflow_d = 1'b1;
            end else if (buf_q[SAMPLE_BITS] != ~lr_q) begin
               shift_d      = '0;
               sync_error_d = 1'b1;
            end else begin
               shift_d = slot_word(buf_q[SAMPLE_BITS-1:0]);
               take    = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         bit_count_q  <= '0;
         lr_q         <= 1'b0;
         shift_q      <= '0;
         underflow_q  <= 1'b0;
         sync_error_q <= 1'b0;
         act_q        <= 1'b0;
         act_first_q  <= 1'b0;
         r_count_q    <= '0;
         buf_valid_q  <= 1'b0;
         buf_q        <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         state_q      <= state_d;
         bit_count_q  <= bit_count_d;
         lr_q         <= lr_d;
         shift_q      <= shift_d;
         underflow_q  <= underflow_d;
         sync_error_q <= sync_error_d;
         act_q        <= act_d;
         act_first_q  <= act_first_d;
         r_count_q    <= r_count_d;
         buf_valid_q  <= buf_valid_d;
         buf_q        <= buf_d;
      end
   end

   assign o_rfifo_activate = act_q;
   assign o_rfifo_strobe   = strobe;
   assign o_i2s_lr         = lr_q;
   assign o_i2s_data       = shift_q[SLOT_BITS-1];
   assign o_underflow      = underflow_q;
   assign o_sync_error     = sync_error_q;

   // Input echo bits are masked so the whole debug word reads zero in reset.
   assign debug = rst ? {19'd0, bit_count_q, state_q, buf_valid_q, strobe, act_q,
                         i_rfifo_ready, i_enable, shift_q[SLOT_BITS-1], lr_q}
                      : 32'd0;

endmodule

// File: tb/tb_i2s_writer_phy.sv
// Directed bench for i2s_writer_phy: a FIFO model feeds blocks and a per-slot
// scoreboard holds the expected slot word and load pulses.
module tb_i2s_writer_phy;
   import i2s_writer_defines::*;

   typedef struct {
      logic [31:0] word;
      logic        uf;
      logic        se;
   } slot_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_enable;
   logic        i_rfifo_ready;
   logic [23:0] i_rfifo_size;
   logic        o_rfifo_activate;
   logic        o_rfifo_strobe;
   logic [31:0] i_rfifo_data;
   logic        o_i2s_lr;
   logic        o_i2s_data;
   logic        o_underflow;
   logic        o_sync_error;
   logic [31:0] debug;

   int          n_vec = 0;
   int          n_err = 0;
   slot_t       sb_q[$];
   logic [31:0] fifo_mem [0:15];
   int          rd_ptr;
   int          n_cyc, stb_cnt, act_hi, last_stb_cyc, fall_cyc, stb_before;
   logic        act_prev;
   logic        run_m;
   int          pos_m;
   logic        lr_m;
   logic [31:0] cur_word;

   always #5 clk = ~clk;

   i2s_writer_phy dut (
      .clk              (clk),
      .rst              (rst),
      .i_enable         (i_enable),
      .i_rfifo_ready    (i_rfifo_ready),
      .i_rfifo_size     (i_rfifo_size),
      .o_rfifo_activate (o_rfifo_activate),
      .o_rfifo_strobe   (o_rfifo_strobe),
      .i_rfifo_data     (i_rfifo_data),
      .o_i2s_lr         (o_i2s_lr),
      .o_i2s_data       (o_i2s_data),
      .o_underflow      (o_underflow),
      .o_sync_error     (o_sync_error),
      .debug            (debug)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [23:0] s);
      return {1'b0, s, 7'h00};
   endfunction

   task automatic push(input logic [31:0] w, input logic uf, input logic se);
      slot_t e;
      e.word = w;
      e.uf   = uf;
      e.se   = se;
      sb_q.push_back(e);
   endtask

   // Per-clock serial monitor against the scoreboard entry of the current slot.
   task automatic monitor();
      slot_t e;
      e.word = '0;
      e.uf   = 1'b0;
      e.se   = 1'b0;
      check("sb_avail", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) e = sb_q[0];
      check("lr", o_i2s_lr, lr_m);
      check("bit_count", debug[12:8], pos_m);
      check("state_run", debug[7], 1);
      check("debug_hi", debug[31:13], 0);
      check("underflow", o_underflow, (pos_m == 0) ? e.uf : 1'b0);
      check("sync_error", o_sync_error, (pos_m == 0) ? e.se : 1'b0);
      cur_word = {cur_word[30:0], o_i2s_data};
      if (pos_m == 31) begin
         check("slot_word", cur_word, e.word);
         if (sb_q.size() != 0) e = sb_q.pop_front();
         pos_m = 0;
         lr_m  = ~lr_m;
      end else begin
         pos_m++;
      end
   endtask

   // One clock: read strobe before the edge, advance the FIFO model after it,
   // sample outputs on the falling edge. Starts and ends just after a negedge.
   task automatic cyc();
      logic stb;
      #1;
      stb = o_rfifo_strobe;
      n_cyc++;
      if (stb) begin
         stb_cnt++;
         last_stb_cyc = n_cyc;
      end
      @(posedge clk);
      #1;
      if (stb) rd_ptr++;
      i_rfifo_data = fifo_mem[rd_ptr];
      if (o_rfifo_activate) i_rfifo_ready = 1'b0;
      @(negedge clk);
      if (o_rfifo_activate) act_hi++;
      if (act_prev && !o_rfifo_activate) fall_cyc = n_cyc;
      act_prev = o_rfifo_activate;
      if (run_m) monitor();
   endtask

   task automatic clear_counts();
      stb_cnt      = 0;
      act_hi       = 0;
      last_stb_cyc = 0;
      fall_cyc     = 0;
   endtask

   task automatic offer_block_a();
      fifo_mem[0] = 32'h00AB_CDEF;
      fifo_mem[1] = 32'hAA12_3456;
      fifo_mem[2] = 32'h7F80_0001;
      fifo_mem[3] = 32'h807F_FFFF;
      rd_ptr        = 0;
      i_rfifo_data  = fifo_mem[0];
      i_rfifo_size  = 24'd4;
      i_rfifo_ready = 1'b1;
   endtask

   task automatic start_run();
      i_enable = 1'b1;
      run_m    = 1'b1;
      pos_m    = 0;
      lr_m     = 1'b0;
      cur_word = '0;
   endtask

   task automatic stop_run(input int left);
      check("sb_left", sb_q.size(), left);
      sb_q.delete();
      i_enable      = 1'b0;
      i_rfifo_ready = 1'b0;
      run_m         = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_lr"},   o_i2s_lr, 0);
      check({tag, "_data"}, o_i2s_data, 0);
      check({tag, "_act"},  o_rfifo_activate, 0);
      check({tag, "_stb"},  o_rfifo_strobe, 0);
      check({tag, "_uf"},   o_underflow, 0);
      check({tag, "_se"},   o_sync_error, 0);
      check({tag, "_dbg"},  debug, 0);
   endtask

   initial begin
      rst           = 1'b0;
      i_enable      = 1'b0;
      i_rfifo_ready = 1'b0;
      i_rfifo_size  = '0;
      i_rfifo_data  = '0;
      for (int i = 0; i < 16; i++) fifo_mem[i] = '0;
      rd_ptr   = 0;
      run_m    = 1'b0;
      act_prev = 1'b0;
      n_cyc    = 0;
      clear_counts();

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      repeat (2) cyc();
      check_all_zero("idle");

      // Four-word block: first L word misses the first (right) load.
      clear_counts();
      offer_block_a();
      push('0, 0, 0);
      push('0, 0, 1);
      push(mk(24'hABCDEF), 0, 0);
      push(mk(24'h123456), 0, 0);
      push(mk(24'h800001), 0, 0);
      push(mk(24'h7FFFFF), 0, 0);
      push('0, 1, 0);
      start_run();
      repeat (7 * 32) cyc();
      stop_run(0);
      check("a_strobes", stb_cnt, 4);
      check("a_fall_after_last", fall_cyc - last_stb_cyc, 1);
      check("a_ptr", rd_ptr, 4);
      cyc();
      check("a_idle_state", debug[7], 0);
      check_all_zero("a_idle");
      repeat (3) cyc();

      // No FIFO data at all.
      clear_counts();
      push('0, 0, 0);
      push('0, 1, 0);
      push('0, 1, 0);
      push('0, 1, 0);
      start_run();
      repeat (4 * 32) cyc();
      stop_run(0);
      check("b_strobes", stb_cnt, 0);
      check("b_act_hi", act_hi, 0);
      repeat (3) cyc();

      // Right word fetched in time for a left load.
      clear_counts();
      fifo_mem[0]  = 32'h8000_F00F;
      rd_ptr       = 0;
      i_rfifo_data = fifo_mem[0];
      i_rfifo_size = 24'd1;
      push('0, 0, 0);
      push('0, 1, 0);
      push('0, 0, 1);
      push(mk(24'h00F00F), 0, 0);
      push('0, 1, 0);
      start_run();
      repeat (37) cyc();
      i_rfifo_ready = 1'b1;
      repeat (5 * 32 - 37) cyc();
      stop_run(0);
      check("c_strobes", stb_cnt, 1);
      repeat (3) cyc();

      // Empty block.
      clear_counts();
      i_rfifo_size  = 24'd0;
      i_rfifo_ready = 1'b1;
      push('0, 0, 0);
      push('0, 1, 0);
      push('0, 1, 0);
      start_run();
      repeat (3 * 32) cyc();
      stop_run(0);
      check("d_act_hi", act_hi, 1);
      check("d_strobes", stb_cnt, 0);
      repeat (3) cyc();

      // Reset at clock 40 of a frame with a block held.
      clear_counts();
      offer_block_a();
      push('0, 0, 0);
      push('0, 0, 1);
      start_run();
      repeat (40) cyc();
      check("e_pre_lr", o_i2s_lr, 1);
      check("e_pre_act", o_rfifo_activate, 1);
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("e_rst");
      run_m = 1'b0;
      sb_q.delete();
      i_rfifo_ready = 1'b0;
      stb_before    = stb_cnt;
      repeat (3) cyc();
      check_all_zero("e_hold");
      check("e_no_strobe", stb_cnt, stb_before);
      rst = 1'b1;
      push('0, 0, 0);
      push('0, 1, 0);
      start_run();
      repeat (2 * 32) cyc();
      stop_run(0);
      repeat (3) cyc();

      // Enable dropped in the middle of a right slot.
      clear_counts();
      offer_block_a();
      push('0, 0, 0);
      push('0, 0, 1);
      push(mk(24'hABCDEF), 0, 0);
      push(mk(24'h123456), 0, 0);
      start_run();
      repeat (3 * 32 + 7) cyc();
      check("f_pre_lr", o_i2s_lr, 1);
      check("f_pre_act", o_rfifo_activate, 1);
      stop_run(1);
      cyc();
      check("f_state", debug[7], 0);
      check("f_bit_count", debug[12:8], 0);
      check("f_lr", o_i2s_lr, 0);
      check("f_data", o_i2s_data, 0);
      check("f_act", o_rfifo_activate, 0);
      check("f_stb", o_rfifo_strobe, 0);
      repeat (2) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
